serial_nibble_rx: RTL and testbench
===================================

Name: serial_nibble_rx

Overview:
Serial frame receiver: the far end of a universal-shift-register transmit path in shift-right mode, which emits bit 0 first.
- Samples one line bit per EN strobe.
- Detects start bit, assembles DATA_W data bits LSB-first, checks stop bit.
- Holds received word for a valid/ack consumer; flags framing errors and overruns.

Parameters:
DATA_W, 4, number of data bits per frame (>=2)
CNT_W, 2, bit-counter width; must satisfy 2**CNT_W >= DATA_W

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous reset, active-high
EN  input  1  bit strobe; SIN sampled only on cycles with EN=1
SIN  input  1  serial line; idle high
ACK  input  1  consumer accepts DOUT; meaningful only when VALID=1
DOUT  output  DATA_W  last good received word; held until overwritten
VALID  output  1  DOUT holds an unconsumed word (level)
FERR  output  1  one-cycle pulse: stop bit sampled low
OVR  output  1  sticky: a good frame overwrote an unconsumed word
BUSY  output  1  high when state != IDLE

Behaviour:
- Interface: one clock (CLK), async active-high reset (RST). All outputs registered except BUSY (decoded from state).
- Reset values: state=IDLE, shift reg=0, bit count=0, DOUT=0, VALID=0, FERR=0, OVR=0, BUSY=0. Reset mid-frame discards the partial frame.
- FSM states: IDLE, DATA, STOP, BREAK. Transitions occur only on EN=1 cycles. With EN=0, state, shift reg and count hold.
- IDLE: on EN & SIN=0 (start bit), go to DATA and clear count. On EN & SIN=1, stay.
- DATA: on EN, shift reg <= {SIN, sh[DATA_W-1:1]} (first bit lands at LSB after DATA_W shifts) and count++. On the EN where count==DATA_W-1, go to STOP.
- STOP, EN & SIN=1 (good frame):
  - DOUT<=sh, VALID<=1, go to IDLE.
  - If VALID=1 and ACK=0 that cycle, also set OVR<=1; the newest word wins.
- STOP, EN & SIN=0 (framing error):
  - FERR<=1 for exactly one cycle; DOUT/VALID/OVR unchanged.
  - Go to BREAK.
- BREAK: stay until EN & SIN=1, then go to IDLE. A low line is never taken as a start bit while in BREAK.
- ACK: when VALID=1 & ACK=1, clear VALID<=0 and OVR<=0. ACK while VALID=0 is ignored.
- Simultaneous ACK with a good stop bit: the new word loads, VALID stays 1, OVR is cleared, not set.
- Latency: VALID/DOUT update on the clock edge that samples the stop bit. Minimum frame is DATA_W+2 EN strobes; back-to-back frames need no idle bit.
- FERR defaults to 0 every cycle unless set as above.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, DATA=2'd1, STOP=2'd2, BREAK=2'd3) and the default DATA_W.
- No sub-module. Shift reg, counter and FSM are small enough to live in one module.

Test Plan:
- Reset mid-DATA: assert RST after 2 data bits, then send a clean frame -> only the clean frame's word appears; VALID=0 and OVR=0 right after reset.
- Basic frame, DATA_W=4, EN every cycle: SIN sequence 0,0,1,0,1,1 (start, 0xA LSB-first, stop) -> DOUT=4'hA and VALID=1 after the 6th edge; BUSY high for 5 cycles; then ACK -> VALID=0.
- Sparse EN: same 0xA frame with EN high every 3rd cycle and SIN toggling garbage on EN=0 cycles -> DOUT=4'hA; garbage ignored.
- Framing error: 0,1,1,1,1,0 then SIN held 0 for 4 EN strobes, then 1 -> FERR pulses once; DOUT/VALID unchanged; no new frame starts until SIN returns high; next frame 0x5 received correctly.
- Overrun: receive 0x3 without ACK, then receive 0xC -> DOUT=4'hC, VALID=1, OVR=1; ACK clears both.
- ACK coincident with stop bit of the next frame (0x6 pending, 0x9 arriving) -> DOUT=4'h9, VALID=1, OVR=0.

Source files
------------

// File: rtl/serial_nibble_rx_pkg.sv
// Shared definitions for the serial frame receiver.
//   state_t        : receiver FSM encoding (IDLE/DATA/STOP/BREAK)
//   DEFAULT_DATA_W : default number of data bits per frame
//   DEFAULT_CNT_W  : default bit-counter width
package serial_nibble_rx_pkg;

    localparam int unsigned DEFAULT_DATA_W = 4;
    localparam int unsigned DEFAULT_CNT_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STOP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

endpackage : serial_nibble_rx_pkg

// File: rtl/serial_nibble_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, stop bit.
// One line bit is sampled per EN strobe.
// Ports:
//   CLK   : rising-edge clock
//   RST   : asynchronous reset, active-high
//   EN    : bit strobe, SIN sampled only when EN=1
//   SIN   : serial line, idle high
//   ACK   : consumer accepts DOUT (ignored while VALID=0)
//   DOUT  : last good received word, held until overwritten
//   VALID : DOUT holds an unconsumed word
//   FERR  : one-cycle pulse, stop bit sampled low
//   OVR   : sticky, a good frame overwrote an unconsumed word
//   BUSY  : combinational, high whenever the receiver is not idle
module serial_nibble_rx
    import serial_nibble_rx_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              SIN,
    input  logic              ACK,
    output logic [DATA_W-1:0] DOUT,
    output logic              VALID,
    output logic              FERR,
    output logic              OVR,
    output logic              BUSY
);

    state_t             state, state_d;
    logic [DATA_W-1:0]  sh, sh_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [DATA_W-1:0]  dout_d;
    logic               valid_d;
    logic               ferr_d;
    logic               ovr_d;

    // State and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            sh    <= '0;
            cnt   <= '0;
            DOUT  <= '0;
            VALID <= 1'b0;
            FERR  <= 1'b0;
            OVR   <= 1'b0;
        end else begin
            state <= state_d;
            sh    <= sh_d;
            cnt   <= cnt_d;
            DOUT  <= dout_d;
            VALID <= valid_d;
            FERR  <= ferr_d;
            OVR   <= ovr_d;
        end
    end

    // Next-state, shift/count and consumer-handshake logic
    always_comb begin
        state_d = state;
        sh_d    = sh;
        cnt_d   = cnt;
        dout_d  = DOUT;
        valid_d = VALID;
        ferr_d  = 1'b0;
        ovr_d   = OVR;

        // Consumer takes the word; a good stop bit below may reload VALID.
        if (VALID && ACK) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (EN && !SIN) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (EN) begin
                    // First bit received ends up at the LSB after DATA_W shifts.
                    sh_d  = {SIN, sh[DATA_W-1:1]};
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (EN) begin
                    if (SIN) begin
                        dout_d  = sh;
                        valid_d = 1'b1;
                        // Overrun only if the old word was not accepted this cycle.
                        if (VALID && !ACK) begin
                            ovr_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Wait for the line to return high before hunting for a start bit.
                if (EN && SIN) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign BUSY = (state != ST_IDLE);

endmodule : serial_nibble_rx

// File: tb/tb_serial_nibble_rx.sv
// Self-checking bench for serial_nibble_rx with a frame-level reference model.
module tb_serial_nibble_rx;

    localparam int unsigned DW = 4;

    localparam int EV_NONE = 0;
    localparam int EV_GOOD = 1;
    localparam int EV_BAD  = 2;

    logic          CLK;
    logic          RST;
    logic          EN;
    logic          SIN;
    logic          ACK;
    logic [DW-1:0] DOUT;
    logic          VALID;
    logic          FERR;
    logic          OVR;
    logic          BUSY;

    int errors;
    int checks;
    int ack_pct;

    // Reference model state, updated once per clock edge from frame-level events
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_ferr;
    logic          m_ovr;
    logic          m_busy;

    serial_nibble_rx #(.DATA_W(DW), .CNT_W(2)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .SIN   (SIN),
        .ACK   (ACK),
        .DOUT  (DOUT),
        .VALID (VALID),
        .FERR  (FERR),
        .OVR   (OVR),
        .BUSY  (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"},  32'(DOUT),  32'(m_dout));
        check({tag, ".valid"}, 32'(VALID), 32'(m_valid));
        check({tag, ".ferr"},  32'(FERR),  32'(m_ferr));
        check({tag, ".ovr"},   32'(OVR),   32'(m_ovr));
        check({tag, ".busy"},  32'(BUSY),  32'(m_busy));
    endtask

    function automatic logic rand_ack();
        return ($urandom_range(0, 99) < 32'(ack_pct));
    endfunction

    task automatic model_reset();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        m_busy  = 1'b0;
    endtask

    // One clock cycle: drive inputs, advance the model on the edge, check after it.
    task automatic tick(input logic en, input logic sin, input logic ack,
                        input int ev, input logic [DW-1:0] w, input logic busy_after);
        logic old_v;
        EN  = en;
        SIN = sin;
        ACK = ack;
        @(posedge CLK);
        old_v = m_valid;
        if (m_valid && ack) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        if (ev == EV_GOOD) begin
            if (old_v && !ack) m_ovr = 1'b1;
            m_dout  = w;
            m_valid = 1'b1;
        end
        m_ferr = (ev == EV_BAD);
        m_busy = busy_after;
        #1;
        check_all("cyc");
    endtask

    // One line bit on an EN strobe, optionally preceded by EN=0 cycles carrying garbage.
    task automatic strobe(input logic b, input int ev, input logic [DW-1:0] w,
                          input logic busy_after, input logic force_ack, input bit sparse);
        if (sparse) begin
            repeat (2) tick(1'b0, 1'($urandom), rand_ack(), EV_NONE, '0, m_busy);
        end
        tick(1'b1, b, force_ack ? 1'b1 : rand_ack(), ev, w, busy_after);
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input bit good, input int nbreak,
                              input bit sparse, input bit ack_at_stop);
        strobe(1'b0, EV_NONE, '0, 1'b1, 1'b0, sparse);
        for (int i = 0; i < int'(DW); i++) strobe(w[i], EV_NONE, '0, 1'b1, 1'b0, sparse);
        if (good) begin
            strobe(1'b1, EV_GOOD, w, 1'b0, ack_at_stop, sparse);
        end else begin
            strobe(1'b0, EV_BAD, '0, 1'b1, 1'b0, sparse);
            repeat (nbreak) strobe(1'b0, EV_NONE, '0, 1'b1, 1'b0, sparse);
            strobe(1'b1, EV_NONE, '0, 1'b0, 1'b0, sparse);
        end
    endtask

    task automatic ack_cycle();
        tick(1'b0, 1'b1, 1'b1, EV_NONE, '0, m_busy);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        ack_pct = 0;
        EN  = 1'b0;
        SIN = 1'b1;
        ACK = 1'b0;
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_all("reset");

        // Reset in the middle of DATA discards the partial frame
        strobe(1'b0, EV_NONE, '0, 1'b1, 1'b0, 1'b0);
        strobe(1'b1, EV_NONE, '0, 1'b1, 1'b0, 1'b0);
        strobe(1'b1, EV_NONE, '0, 1'b1, 1'b0, 1'b0);
        RST = 1'b1;
        model_reset();
        #2;
        check_all("midrst");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        send_frame(4'h7, 1'b1, 0, 1'b0, 1'b0);
        check("midrst_word", 32'(DOUT), 32'h7);
        ack_cycle();

        // Basic 0xA frame, EN every cycle, then ACK
        send_frame(4'hA, 1'b1, 0, 1'b0, 1'b0);
        check("basic_word", 32'(DOUT), 32'hA);
        ack_cycle();
        check("basic_ack", 32'(VALID), 32'h0);

        // Sparse EN with garbage on idle cycles
        send_frame(4'hA, 1'b1, 0, 1'b1, 1'b0);
        check("sparse_word", 32'(DOUT), 32'hA);
        ack_cycle();

        // Framing error: start, 1111, low stop, 4 low strobes, then high
        send_frame(4'hF, 1'b0, 4, 1'b0, 1'b0);
        check("ferr_dout", 32'(DOUT), 32'hA);
        send_frame(4'h5, 1'b1, 0, 1'b0, 1'b0);
        check("ferr_next", 32'(DOUT), 32'h5);
        ack_cycle();

        // Overrun: two words without ACK, newest wins
        send_frame(4'h3, 1'b1, 0, 1'b0, 1'b0);
        send_frame(4'hC, 1'b1, 0, 1'b0, 1'b0);
        check("ovr_flag", 32'(OVR), 32'h1);
        ack_cycle();
        check("ovr_clear", 32'(OVR), 32'h0);

        // ACK coincident with the stop bit of the next frame
        send_frame(4'h6, 1'b1, 0, 1'b0, 1'b0);
        send_frame(4'h9, 1'b1, 0, 1'b0, 1'b1);
        check("coinc_word", 32'(DOUT), 32'h9);
        check("coinc_ovr", 32'(OVR), 32'h0);
        ack_cycle();

        // Randomized frames: mixed good/bad, sparse EN, idle gaps, random ACK
        ack_pct = 25;
        for (int f = 0; f < 60; f++) begin
            send_frame(DW'($urandom), ($urandom_range(0, 4) != 0), int'($urandom_range(0, 3)),
                       1'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) strobe(1'b1, EV_NONE, '0, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_nibble_rx
